// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous input in inputclock cycles,
// and flags a timeout when the input stops producing rising edges.
module clk_period_meter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             inputclock,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  state_t           state, stateNext;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] highLat, highLatNext;
  logic [WIDTH-1:0] periodNext, highTimeNext;
  logic             validNext, lockedNext, timeoutNext;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge inputclock) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Counter restarts at 1 on a rise so a steady P-cycle input reads exactly P
  always_ff @(posedge inputclock) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= WIDTH'(1);
    end else if (cnt != TMO) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge inputclock) begin
    if (rst) begin
      state     <= IDLE;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      highLat   <= '0;
    end else begin
      state     <= stateNext;
      period    <= periodNext;
      high_time <= highTimeNext;
      valid     <= validNext;
      locked    <= lockedNext;
      timeout   <= timeoutNext;
      highLat   <= highLatNext;
    end
  end

  // A rise on the same cycle the counter saturates is a capture, not a timeout
  always_comb begin
    stateNext    = state;
    periodNext   = period;
    highTimeNext = high_time;
    validNext    = 1'b0;
    lockedNext   = locked;
    timeoutNext  = timeout;
    highLatNext  = highLat;
    case (state)
      IDLE: begin
        if (rise) begin
          stateNext   = ARMED;
          timeoutNext = 1'b0;
        end
      end
      ARMED, MEASURE: begin
        if (fall) begin
          highLatNext = cnt;
        end
        if (rise) begin
          periodNext   = cnt;
          highTimeNext = highLat;
          validNext    = 1'b1;
          lockedNext   = 1'b1;
          stateNext    = MEASURE;
        end else if (cnt == TMO) begin
          timeoutNext  = 1'b1;
          lockedNext   = 1'b0;
          periodNext   = '0;
          highTimeNext = '0;
          stateNext    = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: a reference model derived from the sampled
// input waveform queues expected events, a negedge monitor compares every cycle.
module tb_clk_period_meter;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 100;
  localparam int LAT     = 2;

  localparam int EV_ARM = 0;
  localparam int EV_CAP = 1;
  localparam int EV_TMO = 2;

  typedef struct {
    int due;
    int kind;
    int per;
    int hi;
  } ev_t;

  logic             inputclock;
  logic             rst;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  int  checks;
  int  failures;
  int  cyc;
  bit  checking;
  ev_t evq[$];

  int  expPeriod;
  int  expHigh;
  bit  expLocked;
  bit  expTimeout;

  bit  armed;
  bit  prevSample;
  int  lastRise;
  int  lastFall;

  clk_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .inputclock (inputclock),
    .rst        (rst),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  initial begin
    inputclock = 1'b0;
    forever #5 inputclock = ~inputclock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: works on the input as seen at each rising clock edge; every
  // event it predicts becomes visible LAT edges after the sampling edge.
  always @(posedge inputclock) begin
    cyc = cyc + 1;
    if (rst) begin
      evq.delete();
      armed      = 1'b0;
      prevSample = 1'b0;
      expPeriod  = 0;
      expHigh    = 0;
      expLocked  = 1'b0;
      expTimeout = 1'b0;
    end else begin
      automatic bit s      = sig_in;
      automatic bit isRise = s & ~prevSample;
      automatic bit isFall = ~s & prevSample;
      if (armed) begin
        if (isRise && (cyc - lastRise) <= TIMEOUT) begin
          evq.push_back('{due: cyc + LAT, kind: EV_CAP, per: cyc - lastRise, hi: lastFall - lastRise});
          lastRise = cyc;
        end else if (!isRise && (cyc - lastRise) == TIMEOUT) begin
          evq.push_back('{due: cyc + LAT, kind: EV_TMO, per: 0, hi: 0});
          armed = 1'b0;
        end
        if (isFall) lastFall = cyc;
      end else if (isRise) begin
        armed    = 1'b1;
        lastRise = cyc;
        evq.push_back('{due: cyc + LAT, kind: EV_ARM, per: 0, hi: 0});
      end
      prevSample = s;
    end
  end

  // Monitor: applies due events to the expected state and compares all outputs
  always @(negedge inputclock) begin
    if (checking) begin
      automatic bit expValid = 1'b0;
      if (evq.size() > 0 && evq[0].due == cyc) begin
        automatic ev_t e = evq.pop_front();
        case (e.kind)
          EV_CAP: begin
            expValid  = 1'b1;
            expPeriod = e.per;
            expHigh   = e.hi;
            expLocked = 1'b1;
          end
          EV_TMO: begin
            expTimeout = 1'b1;
            expLocked  = 1'b0;
            expPeriod  = 0;
            expHigh    = 0;
          end
          default: expTimeout = 1'b0;
        endcase
      end
      checkOutput("valid", 32'(valid), 32'(expValid));
      checkOutput("period", 32'(period), expPeriod);
      checkOutput("high_time", 32'(high_time), expHigh);
      checkOutput("locked", 32'(locked), 32'(expLocked));
      checkOutput("timeout", 32'(timeout), 32'(expTimeout));
    end
  end

  task automatic applyStimulus(input int hi, input int lo);
    @(negedge inputclock);
    sig_in = 1'b1;
    repeat (hi) @(negedge inputclock);
    sig_in = 1'b0;
    repeat (lo - 1) @(negedge inputclock);
  endtask

  task automatic waitAsync(input int d);
    #d;
    if (($time % 10) == 5) #1;
  endtask

  task automatic pulseReset();
    @(negedge inputclock);
    rst = 1'b1;
    @(negedge inputclock);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    checking = 1'b0;
    sig_in   = 1'b0;
    rst      = 1'b1;
    @(negedge inputclock);
    checking = 1'b1;
    repeat (2) @(negedge inputclock);
    rst = 1'b0;

    // Divider-like waveform: 25 high, 26 low
    repeat (6) applyStimulus(25, 26);
    repeat (3) @(negedge inputclock);
    checkOutput("div_period", 32'(period), 51);
    checkOutput("div_high", 32'(high_time), 25);
    checkOutput("div_locked", 32'(locked), 1);

    // 10 high / 6 low square wave from a fresh reset
    pulseReset();
    repeat (3) applyStimulus(10, 6);
    repeat (3) @(negedge inputclock);
    checkOutput("sq_period", 32'(period), 16);
    checkOutput("sq_high", 32'(high_time), 10);

    // Input stops: timeout, then recovery
    repeat (110) @(negedge inputclock);
    checkOutput("tmo_flag", 32'(timeout), 1);
    checkOutput("tmo_locked", 32'(locked), 0);
    checkOutput("tmo_period", 32'(period), 0);
    repeat (3) applyStimulus(5, 5);

    // Rise exactly at the timeout count, then one cycle too late
    repeat (3) applyStimulus(40, 60);
    @(negedge inputclock);
    sig_in = 1'b1;
    repeat (3) @(negedge inputclock);
    checkOutput("edge_period", 32'(period), TIMEOUT);
    checkOutput("edge_timeout", 32'(timeout), 0);
    sig_in = 1'b0;
    repeat (2) applyStimulus(40, 61);
    repeat (2) applyStimulus(20, 20);

    // Reset in the middle of a high phase after lock
    repeat (3) applyStimulus(20, 20);
    @(negedge inputclock);
    sig_in = 1'b1;
    repeat (10) @(negedge inputclock);
    pulseReset();
    repeat (9) @(negedge inputclock);
    sig_in = 1'b0;
    repeat (3) applyStimulus(12, 18);

    // Randomised high/low lengths, some long enough to time out
    for (int i = 0; i < 40; i++) begin
      applyStimulus(int'($urandom_range(1, 60)), int'($urandom_range(1, 120)));
    end
    repeat (2) applyStimulus(1, 1);

    // Phase-unaligned input with a period of roughly 37 clocks
    @(negedge inputclock);
    #2;
    for (int i = 0; i < 20; i++) begin
      sig_in = 1'b1;
      waitAsync(184);
      sig_in = 1'b0;
      waitAsync(186);
    end

    repeat (5) @(negedge inputclock);
    checkOutput("queue_drained", 32'(evq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
